// File: rtl/reg_file_pkg.sv
// Shared sizing defaults, dump FSM state encoding and data/address aliases for the register-file read side.
// Optional macro REG_FILE_ZERO_REG_EN (consumed by reg_read_mux) hardwires register 0 to zero.
package reg_file_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_ADDR_W = 5;

    typedef logic [DEF_WIDTH-1:0]  reg_t;
    typedef logic [DEF_ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } dump_state_t;

endpackage

// File: rtl/reg_read_mux.sv
// DEPTH:1 register select with same-cycle write bypass; purely combinational, no backpressure.
// Macro REG_FILE_ZERO_REG_EN: register 0 reads as zero and is never bypassed.
module reg_read_mux
    import reg_file_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic [DEPTH*WIDTH-1:0] q_array,
    input  logic [ADDR_W-1:0]      addr,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       data
);

    logic in_range;

    always_comb begin
        data     = '0;
        in_range = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr == ADDR_W'(i)) begin
                data     = q_array[i*WIDTH +: WIDTH];
                in_range = 1'b1;
            end
        end
        // Out-of-range indices stay zero even if a write happens to match them.
        if (in_range && wr_en && (wr_addr == addr)) begin
            data = wr_data;
        end
`ifdef REG_FILE_ZERO_REG_EN
        if (addr == '0) begin
            data = '0;
        end
`endif
    end

endmodule

// File: rtl/reg_file_read.sv
// Two registered read ports (1-cycle latency, bypassed) plus a ready/valid full-array dump; dump_addr holds while dump_ready=0.
// Macro REG_FILE_ZERO_REG_EN: register 0 reads as zero on all consumers.
module reg_file_read
    import reg_file_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DEPTH*WIDTH-1:0] q_array,
    input  logic                   rd_req,
    input  logic [ADDR_W-1:0]      rs1_addr,
    input  logic [ADDR_W-1:0]      rs2_addr,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd1_data,
    output logic [WIDTH-1:0]       rd2_data,
    output logic                   rd_valid,
    input  logic                   dump_start,
    input  logic                   dump_ready,
    output logic                   dump_valid,
    output logic [ADDR_W-1:0]      dump_addr,
    output logic [WIDTH-1:0]       dump_data,
    output logic                   dump_busy,
    output logic                   dump_done
);

    logic [WIDTH-1:0] rd1_sel;
    logic [WIDTH-1:0] rd2_sel;
    logic [WIDTH-1:0] dump_sel;
    dump_state_t      state;

    reg_read_mux #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mux_rs1 (
        .q_array (q_array),
        .addr    (rs1_addr),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .data    (rd1_sel)
    );

    reg_read_mux #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mux_rs2 (
        .q_array (q_array),
        .addr    (rs2_addr),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .data    (rd2_sel)
    );

    reg_read_mux #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mux_dump (
        .q_array (q_array),
        .addr    (dump_addr),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .data    (dump_sel)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd1_data <= '0;
            rd2_data <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd1_data <= rd1_sel;
                rd2_data <= rd2_sel;
            end
        end
    end

    // Dump data stays combinational so a stalled beat always shows the latest write.
    assign dump_data = dump_valid ? dump_sel : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            dump_valid <= 1'b0;
            dump_addr  <= '0;
            dump_busy  <= 1'b0;
            dump_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    dump_done <= 1'b0;
                    if (dump_start) begin
                        state      <= SEND;
                        dump_addr  <= '0;
                        dump_valid <= 1'b1;
                        dump_busy  <= 1'b1;
                    end
                end
                SEND: begin
                    if (dump_ready) begin
                        if (dump_addr == ADDR_W'(DEPTH - 1)) begin
                            state      <= DONE;
                            dump_valid <= 1'b0;
                            dump_busy  <= 1'b0;
                            dump_done  <= 1'b1;
                            dump_addr  <= '0;
                        end else begin
                            dump_addr <= dump_addr + ADDR_W'(1);
                        end
                    end
                end
                DONE: begin
                    dump_done <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    dump_valid <= 1'b0;
                    dump_busy  <= 1'b0;
                    dump_done  <= 1'b0;
                    dump_addr  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_read.sv
// Directed plus randomized bench for reg_file_read against an array-based reference model.
// Define REG_FILE_ZERO_REG_EN on both bench and RTL to exercise the zero-register build.
module tb_reg_file_read;

    logic          clk;
    logic          rst;
    logic [1023:0] q_array;
    logic          rd_req;
    logic [4:0]    rs1_addr;
    logic [4:0]    rs2_addr;
    logic          wr_en;
    logic [4:0]    wr_addr;
    logic [31:0]   wr_data;
    logic [31:0]   rd1_data;
    logic [31:0]   rd2_data;
    logic          rd_valid;
    logic          dump_start;
    logic          dump_ready;
    logic          dump_valid;
    logic [4:0]    dump_addr;
    logic [31:0]   dump_data;
    logic          dump_busy;
    logic          dump_done;

    logic [31:0] mem [32];
    logic [31:0] exp1;
    logic [31:0] exp2;
    logic        expv;
    int          checks;
    int          errors;

    reg_file_read dut (
        .clk        (clk),
        .rst        (rst),
        .q_array    (q_array),
        .rd_req     (rd_req),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd1_data   (rd1_data),
        .rd2_data   (rd2_data),
        .rd_valid   (rd_valid),
        .dump_start (dump_start),
        .dump_ready (dump_ready),
        .dump_valid (dump_valid),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        q_array = '0;
        for (int i = 0; i < 32; i++) q_array[i*32 +: 32] = mem[i];
    end

    // Reference: what a read of register a returns given the write in flight this cycle.
    function automatic logic [31:0] model(input logic [4:0] a, input logic we,
                                          input logic [4:0] wa, input logic [31:0] wd);
`ifdef REG_FILE_ZERO_REG_EN
        if (a == 5'd0) return 32'h0;
`endif
        if (we && wa == a) return wd;
        return mem[a];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic predict();
        if (rd_req) begin
            exp1 = model(rs1_addr, wr_en, wr_addr, wr_data);
            exp2 = model(rs2_addr, wr_en, wr_addr, wr_data);
        end
        expv = rd_req;
    endtask

    // Advance one edge; optionally let the write land in the array like the real write side.
    task automatic tick(input bit commit);
        @(posedge clk);
        #1;
        if (commit && wr_en) mem[wr_addr] = wr_data;
    endtask

    task automatic check_reads();
        check("rd_valid", 32'(rd_valid), 32'(expv));
        check("rd1_data", rd1_data, exp1);
        check("rd2_data", rd2_data, exp2);
    endtask

    task automatic rand_inputs();
        rd_req   = 1'($urandom_range(1, 0));
        rs1_addr = 5'($urandom_range(31, 0));
        rs2_addr = 5'($urandom_range(31, 0));
        wr_en    = 1'($urandom_range(1, 0));
        wr_addr  = ($urandom_range(3, 0) == 0) ? rs1_addr : 5'($urandom_range(31, 0));
        wr_data  = $urandom;
    endtask

    task automatic run_dump(input bit stall, input int abort_at);
        int       cycles;
        int       beats;
        logic [4:0] idx;
        bit       fin;
        bit       hs;
        bit [3:0] pat;
        pat = 4'b1001;
        rd_req = 1'b0;
        wr_en = 1'b0;
        dump_start = 1'b1;
        dump_ready = 1'b1;
        predict();
        tick(0);
        dump_start = 1'b0;
        check_reads();
        idx = 5'd0;
        fin = 1'b0;
        cycles = 0;
        beats = 0;
        while (!fin && cycles < 300) begin
            rand_inputs();
            dump_start = 1'($urandom_range(1, 0));
            dump_ready = stall ? pat[cycles % 4] : 1'b1;
            #1;
            check("dump_valid", 32'(dump_valid), 32'd1);
            check("dump_busy", 32'(dump_busy), 32'd1);
            check("dump_done_early", 32'(dump_done), 32'd0);
            check("dump_addr", 32'(dump_addr), 32'(idx));
            check("dump_data", dump_data, model(idx, wr_en, wr_addr, wr_data));
            if (abort_at == int'(idx)) begin
                rst = 1'b0;
                dump_start = 1'b0;
                #1;
                check("abort_valid", 32'(dump_valid), 32'd0);
                check("abort_busy", 32'(dump_busy), 32'd0);
                check("abort_addr", 32'(dump_addr), 32'd0);
                check("abort_data", dump_data, 32'd0);
                check("abort_rd_valid", 32'(rd_valid), 32'd0);
                check("abort_rd1", rd1_data, 32'd0);
                @(posedge clk);
                #1;
                rst = 1'b1;
                exp1 = 32'd0;
                exp2 = 32'd0;
                expv = 1'b0;
                return;
            end
            hs = dump_ready;
            predict();
            tick(1);
            check_reads();
            cycles++;
            if (hs) begin
                beats++;
                if (idx == 5'd31) fin = 1'b1;
                else idx = idx + 5'd1;
            end
        end
        dump_start = 1'b0;
        check("dump_finished", 32'(fin), 32'd1);
        check("dump_beats", 32'(beats), 32'd32);
        check("dump_cycles", 32'(cycles), stall ? 32'd64 : 32'd32);
        check("dump_done_pulse", 32'(dump_done), 32'd1);
        check("dump_busy_fall", 32'(dump_busy), 32'd0);
        check("dump_valid_off", 32'(dump_valid), 32'd0);
        rd_req = 1'b0;
        wr_en = 1'b0;
        predict();
        tick(0);
        check("dump_done_once", 32'(dump_done), 32'd0);
        check("dump_idle_busy", 32'(dump_busy), 32'd0);
        check("dump_idle_valid", 32'(dump_valid), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        rd_req = 1'b0;
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        wr_en = 1'b0;
        wr_addr = 5'd0;
        wr_data = 32'd0;
        dump_start = 1'b0;
        dump_ready = 1'b0;
        exp1 = 32'd0;
        exp2 = 32'd0;
        expv = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 32'(i) * 32'h01010101;
        #3;
        check("reset_rd1", rd1_data, 32'd0);
        check("reset_rd2", rd2_data, 32'd0);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_dump_valid", 32'(dump_valid), 32'd0);
        check("reset_dump_addr", 32'(dump_addr), 32'd0);
        check("reset_dump_data", dump_data, 32'd0);
        check("reset_dump_busy", 32'(dump_busy), 32'd0);
        check("reset_dump_done", 32'(dump_done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Plain reads of preloaded pattern.
        rd_req = 1'b1; rs1_addr = 5'd3; rs2_addr = 5'd31;
        tick(0);
        check("read_rs1_3", rd1_data, 32'h03030303);
        check("read_rs2_31", rd2_data, 32'h1F1F1F1F);
        check("read_valid", 32'(rd_valid), 32'd1);

        // Same-cycle write to both read addresses, then a non-matching write.
        rs1_addr = 5'd7; rs2_addr = 5'd7;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF;
        tick(0);
        check("bypass_rd1", rd1_data, 32'hDEADBEEF);
        check("bypass_rd2", rd2_data, 32'hDEADBEEF);
        wr_addr = 5'd8;
        tick(0);
        check("nobypass_rd1", rd1_data, 32'h07070707);
        check("nobypass_rd2", rd2_data, 32'h07070707);

        // No request: valid drops, data holds.
        rd_req = 1'b0; wr_en = 1'b0; rs1_addr = 5'd1; rs2_addr = 5'd2;
        tick(0);
        check("idle_valid", 32'(rd_valid), 32'd0);
        check("idle_hold_rd1", rd1_data, 32'h07070707);
        check("idle_hold_rd2", rd2_data, 32'h07070707);

        // Register 0 behaviour with and without the zero-register build.
        mem[0] = 32'hFFFFFFFF;
        rd_req = 1'b1; rs1_addr = 5'd0; rs2_addr = 5'd5;
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
        tick(0);
`ifdef REG_FILE_ZERO_REG_EN
        check("zero_reg_bypass", rd1_data, 32'h0);
`else
        check("zero_reg_bypass", rd1_data, 32'h12345678);
`endif
        check("zero_reg_other", rd2_data, 32'h05050505);
        wr_en = 1'b0;
        tick(0);
`ifdef REG_FILE_ZERO_REG_EN
        check("zero_reg_plain", rd1_data, 32'h0);
`else
        check("zero_reg_plain", rd1_data, 32'hFFFFFFFF);
`endif
        exp1 = rd1_data === 32'hx ? 32'h0 : model(5'd0, 1'b0, 5'd0, 32'h0);
        exp2 = 32'h05050505;
        expv = 1'b1;

        // Randomized reads with random writes committing to the array.
        for (int n = 0; n < 60; n++) begin
            rand_inputs();
            predict();
            tick(1);
            check_reads();
            if (n % 20 == 0) check("rand_dump_idle", 32'(dump_valid), 32'd0);
        end

        mem[0] = 32'hFFFFFFFF;
        run_dump(1'b0, -1);
        run_dump(1'b1, -1);
        run_dump(1'b0, 10);
        for (int n = 0; n < 3; n++) begin
            rd_req = 1'b0;
            wr_en = 1'b0;
            predict();
            tick(0);
            check("post_abort_no_done", 32'(dump_done), 32'd0);
            check("post_abort_idle", 32'(dump_valid), 32'd0);
            check_reads();
        end
        run_dump(1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
